// File: rtl/vpu_alu_int_mul_pipe_pkg.sv
// Shared types and constants for the VPU ALU pipelined integer multiplier.
//   LANES_DEF / OPERAND_WIDTH_DEF : default lane count and per-lane width
//   mul_mode_t                    : decoded multiply mode (signedness, product half)
//   MUL_MODE_*                    : 2-bit mode encodings as seen on mode_i
//   decode_mode()                 : maps the 2-bit encoding onto mul_mode_t
package vpu_alu_int_mul_pipe_pkg;

    localparam int unsigned LANES_DEF         = 4;
    localparam int unsigned OPERAND_WIDTH_DEF = 16;

    typedef struct packed {
        logic is_signed;
        logic hi_half;
    } mul_mode_t;

    // Bit 0 selects signed operands, bit 1 selects the high product half.
    localparam logic [1:0] MUL_MODE_U_LO = 2'b00;
    localparam logic [1:0] MUL_MODE_S_LO = 2'b01;
    localparam logic [1:0] MUL_MODE_U_HI = 2'b10;
    localparam logic [1:0] MUL_MODE_S_HI = 2'b11;

    function automatic mul_mode_t decode_mode(input logic [1:0] enc);
        mul_mode_t m;
        m.is_signed = (enc == MUL_MODE_S_LO) || (enc == MUL_MODE_S_HI);
        m.hi_half   = (enc == MUL_MODE_U_HI) || (enc == MUL_MODE_S_HI);
        return m;
    endfunction

endpackage

// File: rtl/vpu_alu_mul_lane.sv
// One multiply lane, purely combinational.
//   a, b : W-bit operands
//   en   : lane enable; a disabled lane yields res=0, ovf=0
//   mode : signed/unsigned operands and low/high product half
//   res  : selected W-bit half of the 2W-bit product
//   ovf  : low-half result does not represent the full product (always 0 in high mode)
module vpu_alu_mul_lane
    import vpu_alu_int_mul_pipe_pkg::*;
#(
    parameter int unsigned W = OPERAND_WIDTH_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         en,
    input  mul_mode_t    mode,
    output logic [W-1:0] res,
    output logic         ovf
);

    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    logic [2*W-1:0] prod;

    always_comb begin
        // Extending to 2W bits first makes the truncated 2W-bit product exact
        // for both signed and unsigned operands.
        ext_a = mode.is_signed ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        ext_b = mode.is_signed ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        prod  = ext_a * ext_b;
        res   = '0;
        ovf   = 1'b0;
        if (en) begin
            if (mode.hi_half) begin
                res = prod[2*W-1:W];
            end else begin
                res = prod[W-1:0];
                if (mode.is_signed) begin
                    ovf = (prod[2*W-1:W] != {W{prod[W-1]}});
                end else begin
                    ovf = |prod[2*W-1:W];
                end
            end
        end
    end

endmodule

// File: rtl/vpu_alu_int_mul_pipe.sv
// Multi-lane pipelined integer multiplier for the VPU ALU.
//   clk, rst_n         : clock, asynchronous active-low reset
//   valid_i / ready_o  : input beat handshake
//   op_0, op_1         : packed operands, lane k at [k*W +: W]
//   lane_en_i, mode_i  : per-lane enable and multiply mode, captured with the beat
//   valid_o / ready_i  : output beat handshake
//   result_o, ovf_o    : packed per-lane results and overflow flags
// Products are formed in front of the stage 0 register and carried through
// PIPE_STAGES register stages, so latency is exactly PIPE_STAGES cycles.
// A single global stall freezes every stage, bubbles included.
module vpu_alu_int_mul_pipe
    import vpu_alu_int_mul_pipe_pkg::*;
#(
    parameter int unsigned LANES         = LANES_DEF,
    parameter int unsigned OPERAND_WIDTH = OPERAND_WIDTH_DEF,
    parameter int unsigned PIPE_STAGES   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [LANES*OPERAND_WIDTH-1:0] op_0,
    input  logic [LANES*OPERAND_WIDTH-1:0] op_1,
    input  logic [LANES-1:0]               lane_en_i,
    input  logic [1:0]                     mode_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [LANES*OPERAND_WIDTH-1:0] result_o,
    output logic [LANES-1:0]               ovf_o
);

    localparam int unsigned W = OPERAND_WIDTH;

    mul_mode_t              mode;
    logic [LANES*W-1:0]     lane_res;
    logic [LANES-1:0]       lane_ovf;
    logic                   stall;

    logic [PIPE_STAGES-1:0] vld_q;
    logic [LANES*W-1:0]     res_q [PIPE_STAGES];
    logic [LANES-1:0]       ovf_q [PIPE_STAGES];

    assign mode = decode_mode(mode_i);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        vpu_alu_mul_lane #(
            .W (W)
        ) u_lane (
            .a    (op_0[k*W +: W]),
            .b    (op_1[k*W +: W]),
            .en   (lane_en_i[k]),
            .mode (mode),
            .res  (lane_res[k*W +: W]),
            .ovf  (lane_ovf[k])
        );
    end

    assign valid_o  = vld_q[PIPE_STAGES-1];
    assign result_o = res_q[PIPE_STAGES-1];
    assign ovf_o    = ovf_q[PIPE_STAGES-1];
    assign stall    = valid_o && !ready_i;
    assign ready_o  = !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < int'(PIPE_STAGES); s++) begin
                res_q[s] <= '0;
                ovf_q[s] <= '0;
            end
        end else if (!stall) begin
            // ready_o is high whenever we get here, so valid_i alone means accept.
            vld_q[0] <= valid_i;
            // Data only loads on a real beat; idle operands (possibly X) never enter.
            if (valid_i) begin
                res_q[0] <= lane_res;
                ovf_q[0] <= lane_ovf;
            end
            for (int s = 1; s < int'(PIPE_STAGES); s++) begin
                vld_q[s] <= vld_q[s-1];
                res_q[s] <= res_q[s-1];
                ovf_q[s] <= ovf_q[s-1];
            end
        end
    end

endmodule

// File: tb/tb_vpu_alu_int_mul_pipe.sv
module tb_vpu_alu_int_mul_pipe;

    localparam int LANES = 4;
    localparam int W     = 16;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  ovf;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] op_0;
    logic [63:0] op_1;
    logic [3:0]  lane_en_i;
    logic [1:0]  mode_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] result_o;
    logic [3:0]  ovf_o;

    int total = 0;
    int bad   = 0;
    beat_t exp_q[$];

    vpu_alu_int_mul_pipe #(
        .LANES         (LANES),
        .OPERAND_WIDTH (W),
        .PIPE_STAGES   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_0      (op_0),
        .op_1      (op_1),
        .lane_en_i (lane_en_i),
        .mode_i    (mode_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical product.
    function automatic logic [16:0] model_lane(input logic [15:0] a, input logic [15:0] b,
                                               input logic en, input logic [1:0] mode);
        longint pa, pb, p, hi;
        logic [15:0] r;
        logic        o;
        if (!en) return 17'h0;
        pa = longint'(a);
        pb = longint'(b);
        if (mode[0] && a[15]) pa = pa - 65536;
        if (mode[0] && b[15]) pb = pb - 65536;
        p = pa * pb;
        if (mode[1]) begin
            hi = p >>> 16;
            r  = hi[15:0];
            o  = 1'b0;
        end else begin
            r = p[15:0];
            if (mode[0]) o = (p < -32768) || (p > 32767);
            else         o = (p > 65535);
        end
        return {o, r};
    endfunction

    function automatic beat_t model_beat(input logic [63:0] a, input logic [63:0] b,
                                         input logic [3:0] en, input logic [1:0] mode);
        beat_t e;
        logic [16:0] l;
        for (int k = 0; k < LANES; k++) begin
            l = model_lane(a[k*16 +: 16], b[k*16 +: 16], en[k], mode);
            e.res[k*16 +: 16] = l[15:0];
            e.ovf[k]          = l[16];
        end
        return e;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic new_beat();
        op_0      = {rnd16(), rnd16(), rnd16(), rnd16()};
        op_1      = {rnd16(), rnd16(), rnd16(), rnd16()};
        lane_en_i = 4'($urandom);
        mode_i    = 2'($urandom);
    endtask

    // Called at posedge+1 with inputs set; checks the output beat against the
    // scoreboard, records an accepted input beat, and advances one cycle.
    task automatic tick();
        beat_t e;
        #1;
        if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("valid_without_beat", {63'b0, valid_o}, 64'h0);
            end else begin
                e = exp_q[0];
                chk("sb_result", result_o, e.res);
                chk("sb_ovf", {60'b0, ovf_o}, {60'b0, e.ovf});
                if (ready_i) void'(exp_q.pop_front());
            end
        end
        if (valid_i && ready_o) exp_q.push_back(model_beat(op_0, op_1, lane_en_i, mode_i));
        @(posedge clk);
        #1;
    endtask

    // Issue one beat with ready_i=1 and stop in the cycle it should reach valid_o.
    task automatic send_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] en, input logic [1:0] mode);
        op_0 = a; op_1 = b; lane_en_i = en; mode_i = mode;
        valid_i = 1'b1;
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk({tag, "_lat_c1"}, {63'b0, valid_o}, 64'h0);
        tick();
        chk({tag, "_lat_c2"}, {63'b0, valid_o}, 64'h0);
        tick();
        chk({tag, "_lat_c3"}, {63'b0, valid_o}, 64'h1);
    endtask

    int  sent;
    int  delivered;
    int  low_cnt;
    logic acc;

    initial begin
        rst_n     = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        op_0      = '0;
        op_1      = '0;
        lane_en_i = '0;
        mode_i    = '0;

        // Reset state
        #3;
        chk("rst_valid_o", {63'b0, valid_o}, 64'h0);
        chk("rst_result_o", result_o, 64'h0);
        chk("rst_ovf_o", {60'b0, ovf_o}, 64'h0);
        chk("rst_ready_o", {63'b0, ready_o}, 64'h1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_valid_o", {63'b0, valid_o}, 64'h0);
        chk("post_rst_ready_o", {63'b0, ready_o}, 64'h1);
        @(posedge clk);
        #1;

        // 1: unsigned low
        send_one("t1", {16'h0003, 16'h0004, 16'hFFFF, 16'h00FF},
                 {16'h0005, 16'h0006, 16'h0002, 16'h0101}, 4'hF, 2'b00);
        chk("t1_l0_res", {48'b0, result_o[15:0]}, 64'hFFFF);
        chk("t1_l0_ovf", {63'b0, ovf_o[0]}, 64'h0);
        chk("t1_l1_res", {48'b0, result_o[31:16]}, 64'hFFFE);
        chk("t1_l1_ovf", {63'b0, ovf_o[1]}, 64'h1);
        tick();

        // 2: 0xFFFF * 0x0002 in three modes
        send_one("t2sh", {4{16'hFFFF}}, {4{16'h0002}}, 4'hF, 2'b11);
        chk("t2_s_hi_res", result_o, {4{16'hFFFF}});
        chk("t2_s_hi_ovf", {60'b0, ovf_o}, 64'h0);
        tick();
        send_one("t2uh", {4{16'hFFFF}}, {4{16'h0002}}, 4'hF, 2'b10);
        chk("t2_u_hi_res", result_o, {4{16'h0001}});
        chk("t2_u_hi_ovf", {60'b0, ovf_o}, 64'h0);
        tick();
        send_one("t2sl", {4{16'hFFFF}}, {4{16'h0002}}, 4'hF, 2'b01);
        chk("t2_s_lo_res", result_o, {4{16'hFFFE}});
        chk("t2_s_lo_ovf", {60'b0, ovf_o}, 64'h0);
        tick();

        // 3: signed low boundaries
        send_one("t3", {16'h0, 16'h0, 16'h7FFF, 16'h8000},
                 {16'h0, 16'h0, 16'h0001, 16'hFFFF}, 4'hF, 2'b01);
        chk("t3_l0_res", {48'b0, result_o[15:0]}, 64'h8000);
        chk("t3_l0_ovf", {63'b0, ovf_o[0]}, 64'h1);
        chk("t3_l1_res", {48'b0, result_o[31:16]}, 64'h7FFF);
        chk("t3_l1_ovf", {63'b0, ovf_o[1]}, 64'h0);
        tick();

        // 4: lane mask
        send_one("t4", {4{16'h0003}}, {4{16'h0003}}, 4'b0101, 2'b00);
        chk("t4_res", result_o, {16'h0000, 16'h0009, 16'h0000, 16'h0009});
        chk("t4_ovf", {60'b0, ovf_o}, 64'h0);
        tick();

        // 5: back-to-back stream with a 3-cycle output stall
        sent = 0; delivered = 0; low_cnt = 0;
        new_beat();
        for (int i = 0; i < 64; i++) begin
            if (sent == 8 && exp_q.size() == 0) break;
            ready_i = !(i >= 3 && i <= 5);
            valid_i = (sent < 8);
            #1;
            if (i >= 3 && i <= 5) chk("t5_ready_o_stall", {63'b0, ready_o}, 64'h0);
            if (!ready_o) low_cnt++;
            acc = valid_i && ready_o;
            if (valid_o && ready_i) delivered++;
            tick();
            if (acc) begin
                sent++;
                new_beat();
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        chk("t5_ready_low_cycles", 64'(low_cnt), 64'd3);
        chk("t5_delivered", 64'(delivered), 64'd8);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // 6: reset with two beats in flight
        new_beat();
        valid_i = 1'b1;
        tick();
        new_beat();
        tick();
        valid_i = 1'b0;
        tick();
        chk("t6_pre_rst_valid", {63'b0, valid_o}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid_o", {63'b0, valid_o}, 64'h0);
        chk("t6_rst_result_o", result_o, 64'h0);
        chk("t6_rst_ready_o", {63'b0, ready_o}, 64'h1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t6_no_stale_beat", {63'b0, valid_o}, 64'h0);
            tick();
        end
        send_one("t6new", {16'h0002, 16'h0010, 16'hFFFF, 16'h0007},
                 {16'h0003, 16'h0010, 16'hFFFF, 16'h0006}, 4'hF, 2'b00);
        chk("t6_new_res", result_o, {16'h0006, 16'h0100, 16'h0001, 16'h002A});
        chk("t6_new_ovf", {60'b0, ovf_o}, 64'h2);
        tick();

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            if (!(valid_i && !ready_o)) begin
                new_beat();
                valid_i = ($urandom_range(0, 3) != 0);
            end
            ready_i = ($urandom_range(0, 3) != 0);
            #1;
            acc = valid_i && ready_o;
            tick();
            if (acc) valid_i = 1'b0;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();
        chk("drain_valid_o", {63'b0, valid_o}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
